shiftreg_sipo_rx: RTL and testbench
===================================

# shiftreg_sipo_rx

Serial-in, parallel-out receiver that is the far end of the 4-bit parallel-load shift-register link. It hunts for a frame marker, shifts in WIDTH serial bits per word, and presents each assembled word on a registered parallel output with a valid/ready handshake. It sits between the serial link and the block-level scoreboard or consumer logic, and reports words dropped under backpressure.

## Interface
- WIDTH, 4, data bits per word (≥2)
- MSB_FIRST, 1, 1: first received bit lands in bit WIDTH-1; 0: first bit lands in bit 0
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- serial_data_in  input  1  serial bit, sampled when serial_valid=1
- serial_valid  input  1  qualifies serial_data_in this cycle
- frame_start  input  1  marks serial_data_in as bit 0 of a new word; resynchronises framing
- parallel_data_out  output  WIDTH  assembled word, stable while data_valid=1
- data_valid  output  1  parallel_data_out holds an unconsumed word
- data_ready  input  1  consumer accepts; transfer when data_valid & data_ready
- overrun  output  1  sticky: a completed word was dropped
- overrun_clr  input  1  synchronous clear of overrun
- parity_err  output  1  present only with SIPO_PARITY_EN (see Configuration)

## Operation
- FSM states: HUNT, SHIFT, PARITY (PARITY exists only with SIPO_PARITY_EN).
- HUNT: serial bits are ignored. serial_valid & frame_start → bit captured as bit 0, bit counter = 1, go to SHIFT.
- SHIFT: each serial_valid shifts one bit in (position per MSB_FIRST) and increments the counter. Cycles without serial_valid hold state.
- Word complete: on the WIDTH-th valid bit, the shift register contents plus the current bit are offered to the holding register. The counter returns to 0 and the FSM stays in SHIFT, so back-to-back words need no further frame_start.
- frame_start & serial_valid in SHIFT: the partial word is discarded, and the bit becomes bit 0 of a new word (counter = 1).
- frame_start without serial_valid: counter = 0, state = SHIFT, partial word discarded.
- frame_start on the final bit of a word: treated as a resync; that word is not delivered.
- Holding register behaviour on a completed word:
  - If empty, or being consumed in the same cycle (data_valid & data_ready), it loads the word and data_valid is 1 next cycle.
  - Otherwise the new word is dropped, the holding register keeps the old word, and overrun is set.
- data_valid & data_ready with no completion: data_valid clears next cycle.
- overrun stays set until overrun_clr or reset. If a drop occurs in the same cycle as overrun_clr, the set wins.
- Reset mid-word: the partial word and any held word are lost. The state returns to HUNT.

## Timing
- Reset values: parallel_data_out=0, data_valid=0, overrun=0, parity_err=0, state=HUNT, counter=0.
- Latency: if the last data bit (or the parity bit, when enabled) is sampled at edge N, data_valid and parallel_data_out update at edge N.
- Throughput: one word per WIDTH valid cycles (WIDTH+1 with parity), with no dead cycles between words.
- All outputs are registered; no input-to-output combinational path.
- parallel_data_out changes only when the holding register loads.

## Configuration
- SIPO_PARITY_EN defined:
  - An even-parity bit follows each word's data bits; a word completes on the (WIDTH+1)-th valid bit. The FSM goes SHIFT → PARITY after WIDTH bits.
  - parity_err is loaded alongside parallel_data_out: it is 1 if the XOR of the data bits and the parity bit is 1.
  - A word with bad parity is still delivered.
- SIPO_PARITY_EN undefined: the parity_err port, the PARITY state and the parity logic are absent. A word completes on the WIDTH-th bit.

## Structure
- Package shiftreg_pkg holds:
  - the FSM state enum typedef
  - the default WIDTH constant
  - a localparam function for bit-counter width: clog2(WIDTH+1)
- Sub-module sipo_hold_reg contains the holding register, the data_valid/data_ready handshake and overrun generation. The top level keeps the FSM, counter and shift register.

## Test plan
- Reset released, then frame_start with bits 1,0,1,1 (MSB_FIRST=1, data_ready=1) → parallel_data_out=4'hB, data_valid for one cycle. Repeat with MSB_FIRST=0 → 4'hD.
- Bits streamed before any frame_start → no data_valid. Then frame_start + 0,1,1,0 followed by 1,1,1,1 without a second frame_start → 4'h6 then 4'hF, back-to-back.
- data_ready=0 while two words 4'h3 and 4'hA arrive → output holds 4'h3 and overrun=1. Pulse overrun_clr → overrun=0. Next word completing in the same cycle as data_ready=1 → loads without overrun.
- Two bits 1,1 received, then frame_start + 0,0,0,1 → 4'h1; the partial bits are discarded.
- Assert reset after two bits of a word and with a word held → all outputs 0, state HUNT. Bits without frame_start → no output.
- SIPO_PARITY_EN: bits 1,0,1,1 then parity 1 → 4'hB with parity_err=0. Parity bit 0 → parity_err=1, word still delivered.

Source files
------------

// File: rtl/shiftreg_pkg.sv
// Shared types and constants for the SIPO receiver.
// With SIPO_PARITY_EN defined, the state enum gains the PARITY state.
package shiftreg_pkg;

  localparam int SIPO_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_SHIFT = 2'd1
`ifdef SIPO_PARITY_EN
    , ST_PARITY = 2'd2
`endif
  } sipo_state_t;

  // Bit counter must hold 0..WIDTH.
  function automatic int sipo_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// Output holding register for the SIPO receiver: valid/ready handshake and sticky overrun.
// SIPO_PARITY_EN adds a parity_err flag that is loaded alongside the data word.
module sipo_hold_reg
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
`ifdef SIPO_PARITY_EN
  input  logic             load_perr,
`endif
  input  logic             data_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] parallel_data_out,
  output logic             data_valid,
  output logic             overrun
`ifdef SIPO_PARITY_EN
  , output logic           parity_err
`endif
);

  logic accept;
  logic drop;

  // A word may land if the register is empty or is being drained this same cycle.
  assign accept = ~data_valid | data_ready;
  assign drop   = load & ~accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parallel_data_out <= '0;
      data_valid        <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      if (load && accept) begin
        parallel_data_out <= load_word;
        data_valid        <= 1'b1;
      end else if (data_ready) begin
        data_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err <= 1'b0;
    end else if (load && accept) begin
      parity_err <= load_perr;
    end
  end
`endif

endmodule

// File: rtl/shiftreg_sipo_rx.sv
// Serial-in parallel-out receiver: frame hunting, bit assembly and hand-off to the holding register.
// Optional even-parity bit per word when SIPO_PARITY_EN is defined.
//
// state  | meaning
// HUNT   | waiting for frame_start; serial bits ignored
// SHIFT  | collecting data bits; counter = bits received in current word
// PARITY | all data bits in, next valid bit is the parity bit (SIPO_PARITY_EN only)
module shiftreg_sipo_rx
  import shiftreg_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH_DEFAULT,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_data_in,
  input  logic             serial_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] parallel_data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  input  logic             overrun_clr
`ifdef SIPO_PARITY_EN
  , output logic           parity_err
`endif
);

  localparam int CW = sipo_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sipo_state_t      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_val;
  logic             word_done;
`ifdef SIPO_PARITY_EN
  logic             perr_d;
`endif

  // Shifting direction places the first bit of a full word at the MSB or LSB.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST != 0) return {cur[WIDTH-2:0], b};
    else                return {b, cur[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_HUNT;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    word_val  = shift_in(shift_q, serial_data_in);
`ifdef SIPO_PARITY_EN
    perr_d    = 1'b0;
`endif
    // frame_start resynchronises from any state and overrides a completing word.
    if (frame_start) begin
      state_d = ST_SHIFT;
      if (serial_valid) begin
        shift_d = shift_in('0, serial_data_in);
        cnt_d   = CW'(1);
      end else begin
        shift_d = '0;
        cnt_d   = '0;
      end
    end else if (serial_valid) begin
      case (state_q)
        ST_HUNT: state_d = ST_HUNT;
        ST_SHIFT: begin
          shift_d = word_val;
          if (cnt_q == LAST) begin
`ifdef SIPO_PARITY_EN
            state_d = ST_PARITY;
            cnt_d   = CW'(WIDTH);
`else
            word_done = 1'b1;
            cnt_d     = '0;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef SIPO_PARITY_EN
        ST_PARITY: begin
          word_done = 1'b1;
          word_val  = shift_q;
          perr_d    = ^{shift_q, serial_data_in};
          state_d   = ST_SHIFT;
          cnt_d     = '0;
        end
`endif
        default: begin
          state_d = ST_HUNT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  sipo_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk               (clk),
    .reset             (reset),
    .load              (word_done),
    .load_word         (word_val),
`ifdef SIPO_PARITY_EN
    .load_perr         (perr_d),
`endif
    .data_ready        (data_ready),
    .overrun_clr       (overrun_clr),
    .parallel_data_out (parallel_data_out),
    .data_valid        (data_valid),
    .overrun           (overrun)
`ifdef SIPO_PARITY_EN
    , .parity_err      (parity_err)
`endif
  );

endmodule

// File: tb/tb_shiftreg_sipo_rx.sv
// Scoreboard bench for shiftreg_sipo_rx: MSB-first and LSB-first instances share one stimulus stream.
// Follows SIPO_PARITY_EN for the parity bit and parity_err checks.
module tb_shiftreg_sipo_rx;
  localparam int W = 4;
`ifdef SIPO_PARITY_EN
  localparam int NB = W + 1;
  logic par_bad = 1'b0;
  logic perr_m, perr_l;
`else
  localparam int NB = W;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic serial_data_in = 1'b0, serial_valid = 1'b0, frame_start = 1'b0;
  logic data_ready = 1'b0, overrun_clr = 1'b0;
  logic [W-1:0] pdo_m, pdo_l;
  logic dv_m, dv_l, ovr_m, ovr_l;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct { int wm; int wl; int perr; } exp_t;
  exp_t expq[$];
  bit   bits[$];
  bit   hunting = 1'b1;
  bit   m_held = 1'b0;
  bit   m_ovr = 1'b0;

  always #5 clk = ~clk;

  shiftreg_sipo_rx #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .serial_data_in(serial_data_in), .serial_valid(serial_valid),
    .frame_start(frame_start), .parallel_data_out(pdo_m), .data_valid(dv_m),
    .data_ready(data_ready), .overrun(ovr_m), .overrun_clr(overrun_clr)
`ifdef SIPO_PARITY_EN
    , .parity_err(perr_m)
`endif
  );

  shiftreg_sipo_rx #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .serial_data_in(serial_data_in), .serial_valid(serial_valid),
    .frame_start(frame_start), .parallel_data_out(pdo_l), .data_valid(dv_l),
    .data_ready(data_ready), .overrun(ovr_l), .overrun_clr(overrun_clr)
`ifdef SIPO_PARITY_EN
    , .parity_err(perr_l)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: words are lists of received bits, turned into numbers when complete.
  initial begin : model
    bit xfer, done, drop;
    exp_t e;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        bits.delete();
        hunting = 1'b1;
        m_held  = 1'b0;
        m_ovr   = 1'b0;
        expq.delete();
      end else begin
        xfer = m_held && data_ready;
        done = 1'b0;
        drop = 1'b0;
        e = '{0, 0, 0};
        if (frame_start) begin
          bits.delete();
          hunting = 1'b0;
          if (serial_valid) bits.push_back(serial_data_in);
        end else if (serial_valid && !hunting) begin
          bits.push_back(serial_data_in);
          if (bits.size() == NB) begin
            done = 1'b1;
            for (int i = 0; i < W; i++) begin
              e.wm += int'(bits[i]) << (W - 1 - i);
              e.wl += int'(bits[i]) << i;
            end
            for (int i = 0; i < NB; i++) e.perr ^= int'(bits[i]);
            bits.delete();
          end
        end
        if (done && (!m_held || xfer)) begin
          expq.push_back(e);
          m_held = 1'b1;
        end else if (done) begin
          drop = 1'b1;
        end else if (xfer) begin
          m_held = 1'b0;
        end
        if (drop) m_ovr = 1'b1;
        else if (overrun_clr) m_ovr = 1'b0;
      end
    end
  end

  // Monitor: compares DUT outputs against the model between clock edges.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("rst_data_m", int'(pdo_m), 0);
        check("rst_data_l", int'(pdo_l), 0);
        check("rst_valid", int'(dv_m | dv_l), 0);
        check("rst_overrun", int'(ovr_m | ovr_l), 0);
      end else begin
        check("valid_m", int'(dv_m), int'(m_held));
        check("valid_l", int'(dv_l), int'(m_held));
        check("overrun_m", int'(ovr_m), int'(m_ovr));
        check("overrun_l", int'(ovr_l), int'(m_ovr));
        if (m_held) begin
          if (expq.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard: word held but none expected (t=%0t)", $time);
          end else begin
            e = expq[0];
            check("word_msb", int'(pdo_m), e.wm);
            check("word_lsb", int'(pdo_l), e.wl);
`ifdef SIPO_PARITY_EN
            check("parity_err_m", int'(perr_m), e.perr);
            check("parity_err_l", int'(perr_l), e.perr);
`endif
            if (data_ready) void'(expq.pop_front());
          end
        end
      end
    end
  end

  task automatic drive(input logic sv, input logic sd, input logic fs, input logic rdy, input logic oc);
    @(posedge clk);
    #2;
    serial_valid   = sv;
    serial_data_in = sd;
    frame_start    = fs;
    data_ready     = rdy;
    overrun_clr    = oc;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  // seq is sent MSB first on the wire: 4'b1011 sends 1,0,1,1.
  task automatic send_word(input logic [W-1:0] seq, input logic fs, input logic rdy, input logic rdy_last);
    for (int i = 0; i < W; i++)
      drive(1'b1, seq[W-1-i], (i == 0) ? fs : 1'b0, (i == NB - 1) ? rdy_last : rdy, 1'b0);
`ifdef SIPO_PARITY_EN
    drive(1'b1, (^seq) ^ par_bad, 1'b0, rdy_last, 1'b0);
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // Bits before any frame_start are ignored.
    for (int i = 0; i < 6; i++) drive(1'b1, 1'($urandom_range(1, 0)), 1'b0, 1'b1, 1'b0);
    idle(1, 1'b1);
    @(negedge clk);
    check("hunt_no_valid", int'(dv_m | dv_l), 0);

    send_word(4'b1011, 1'b1, 1'b1, 1'b1);
    idle(1, 1'b1);
    @(negedge clk);
    check("t1_msb_B", int'(pdo_m), 'hB);
    check("t1_lsb_D", int'(pdo_l), 'hD);
    check("t1_valid", int'(dv_m), 1);
    @(negedge clk);
    check("t1_valid_one_cycle", int'(dv_m), 0);

    send_word(4'b0110, 1'b1, 1'b1, 1'b1);
    send_word(4'b1111, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);
    @(negedge clk);
    check("t2_back_to_back_F", int'(pdo_m), 'hF);

    send_word(4'b0011, 1'b1, 1'b0, 1'b0);
    send_word(4'b1010, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    @(negedge clk);
    check("t3_hold_3", int'(pdo_m), 'h3);
    check("t3_hold_lsb_C", int'(pdo_l), 'hC);
    check("t3_overrun_set", int'(ovr_m), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);
    @(negedge clk);
    check("t3_overrun_clr", int'(ovr_m), 0);
    send_word(4'b0101, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);
    @(negedge clk);
    check("t3_same_cycle_load", int'(pdo_m), 'h5);
    check("t3_same_cycle_lsb", int'(pdo_l), 'hA);
    check("t3_no_overrun", int'(ovr_m), 0);
    idle(2, 1'b1);

    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_word(4'b0001, 1'b1, 1'b1, 1'b1);
    idle(1, 1'b1);
    @(negedge clk);
    check("t4_resync_msb", int'(pdo_m), 'h1);
    check("t4_resync_lsb", int'(pdo_l), 'h8);

    // Reset with a word held and a partial word in flight.
    send_word(4'b0011, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    serial_valid = 1'b0;
    frame_start = 1'b0;
    #1;
    check("t5_reset_data", int'(pdo_m), 0);
    check("t5_reset_valid", int'(dv_m), 0);
    @(posedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'($urandom_range(1, 0)), 1'b0, 1'b1, 1'b0);
    idle(1, 1'b1);
    @(negedge clk);
    check("t5_hunt_after_reset", int'(dv_m | dv_l), 0);

`ifdef SIPO_PARITY_EN
    par_bad = 1'b0;
    send_word(4'b1011, 1'b1, 1'b1, 1'b1);
    idle(1, 1'b1);
    @(negedge clk);
    check("t6_parity_ok_word", int'(pdo_m), 'hB);
    check("t6_parity_ok", int'(perr_m), 0);
    par_bad = 1'b1;
    send_word(4'b1011, 1'b1, 1'b1, 1'b1);
    idle(1, 1'b1);
    @(negedge clk);
    check("t6_parity_bad_word", int'(pdo_m), 'hB);
    check("t6_parity_bad", int'(perr_m), 1);
    par_bad = 1'b0;
`endif

    for (int n = 0; n < 4000; n++)
      drive($urandom_range(3, 0) != 0, 1'($urandom_range(1, 0)), $urandom_range(15, 0) == 0,
            $urandom_range(3, 0) != 0, $urandom_range(31, 0) == 0);
    idle(4, 1'b1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
